clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DIVW, default 25: width of each channel's divide value and counter.
REQ-003 Parameter DEF_DIV, default 2: divide value loaded into every channel at reset; 0 means disabled.
REQ-004 Port clk, input, 1: system clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port en, input, 1: global run enable; when low, all counters hold.
REQ-007 Port sync_clr, input, 1: single-cycle phase-align request covering all channels.
REQ-008 Port cfg_valid, input, 1: configuration write request.
REQ-009 Port cfg_ready, output, 1: block can accept a configuration write.
REQ-010 Port cfg_ch, input, 4: target channel index for the configuration write.
REQ-011 Port cfg_div, input, DIVW: new divide value for the target channel.
REQ-012 Port cfg_err, output, 1: one-cycle pulse when a write targets an out-of-range channel.
REQ-013 Port tick, output, NCH: per-channel one-cycle terminal-count pulse.
REQ-014 Port sq, output, NCH: per-channel square wave with a period of 2*div cycles.

Function
REQ-015 Each channel SHALL hold a registered counter cnt, range 0..div-1, and an active divide register div.
REQ-016 If en=1 and div!=0, cnt SHALL increment each cycle and wrap to 0 after reaching div-1.
REQ-017 tick[k] SHALL be combinationally high when en=1, div!=0 and cnt=div-1; it is a single-cycle pulse, or constant high when div=1.
REQ-018 sq[k] SHALL be a register that toggles on every cycle where tick[k]=1, giving 50% duty for any div>=1.
REQ-019 If div=0, the channel SHALL force cnt=0, sq=0 and tick=0.
REQ-020 If en=0, cnt and sq SHALL hold and all tick outputs SHALL be 0.
REQ-021 A configuration write is accepted on any cycle where cfg_valid=1 and cfg_ready=1.
REQ-022 An accepted write SHALL go into a single shared pending slot holding the channel and value; cfg_ready SHALL be the inverse of the pending flag.
REQ-023 The pending value SHALL be applied to its channel, and the slot cleared, under any of these conditions:
  - at that channel's terminal count (tick=1), with cnt set to 0 on the same edge;
  - on the first cycle after acceptance if the channel's current div=0;
  - on the first cycle after acceptance if en=0.
REQ-024 While a new div is applied, the old div SHALL still govern the cycle in which the tick occurs, so no output period is ever truncated (glitch-free).
REQ-025 If cfg_ch>=NCH, the write SHALL still be accepted, but the pending slot is not set; cfg_err SHALL pulse in the next cycle and cfg_ready SHALL stay 1.
REQ-026 sync_clr=1 SHALL set every cnt=0 and every sq=0 on the next edge, apply any pending value immediately, and suppress tick in that cycle.
REQ-027 If sync_clr and a configuration accept happen in the same cycle, the new write SHALL be applied as part of the clear.
REQ-028 Writing div=0 to a running channel SHALL take effect at its next tick; sq SHALL then be forced to 0.

Reset
REQ-029 While rst_n=0, the block SHALL set:
  - every cnt to 0, every sq to 0, and every div to DEF_DIV;
  - the pending flag to 0, cfg_ready to 1, and cfg_err to 0.
REQ-030 Reset SHALL take effect asynchronously, including mid-period and with an update pending; a pending update SHALL be discarded.

Structure
REQ-031 A shared package clk_div_pkg SHALL hold the CH_IDX_W=4 constant and the NCH maximum of 16.
REQ-032 The per-channel counter, tick and sq logic SHALL be a sub-module clk_div_chan, instantiated NCH times.
REQ-033 The pending slot and handshake SHALL live in the top level.

Verification
REQ-034 Reset with DEF_DIV=2 and en=1: each tick pulses every 2 cycles and each sq toggles every 2 cycles, giving a period of 4.
REQ-035 Write ch1 div=5 while its cnt=0 at old div 3: the period stays 3 until the tick, then ticks every 5 cycles; cfg_ready is low until that tick.
REQ-036 Write cfg_ch=9 with NCH=4: cfg_err pulses exactly once, cfg_ready stays 1, and no channel changes.
REQ-037 Channels running at div 3 and 7, then a sync_clr pulse: the next cycle has all cnt=0 and sq=0, and the first ticks come after 3 and 7 cycles.
REQ-038 Write ch0 div=1: tick0 is constant high and sq0 toggles every cycle; then writing div=0 makes tick0 and sq0 go low after the next tick.
REQ-039 Assert rst_n low mid-period with a write pending: all outputs return to reset values immediately, and after release the pending value is not applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: channel index width and
// the largest channel count the index can address.
package clk_div_pkg;

    localparam int CH_IDX_W = 4;
    localparam int NCH_MAX  = 16;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, terminal-count tick and a
// 50% square wave, with glitch-free reload of the divide value.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIVW    = 25,
    parameter int DEF_DIV = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sync_clr,
    input  logic            load,
    input  logic [DIVW-1:0] load_div,
    output logic            tick,
    output logic            sq,
    output logic            div_zero
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div;
    logic            sq_r;
    logic            at_term;

    assign at_term  = (cnt == div - DIVW'(1));
    assign div_zero = (div == '0);
    assign tick     = en & ~sync_clr & ~div_zero & at_term;
    assign sq       = sq_r;

    // A reload lands on the tick edge, so the old divide value still sets
    // the length of the period that is ending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= DIVW'(DEF_DIV);
            sq_r <= 1'b0;
        end else if (sync_clr) begin
            cnt  <= '0;
            sq_r <= 1'b0;
            if (load) begin
                div <= load_div;
            end
        end else if (load) begin
            cnt <= '0;
            div <= load_div;
            if (load_div == '0) begin
                sq_r <= 1'b0;
            end else if (tick) begin
                sq_r <= ~sq_r;
            end
        end else if (div_zero) begin
            cnt  <= '0;
            sq_r <= 1'b0;
        end else if (en) begin
            cnt <= at_term ? '0 : cnt + DIVW'(1);
            if (tick) begin
                sq_r <= ~sq_r;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH clock dividers sharing one pending configuration slot that
// is applied to its channel at a safe point (tick, disabled, idle or clear).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIVW    = 25,
    parameter int DEF_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync_clr,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [DIVW-1:0]     cfg_div,
    output logic                cfg_err,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      sq
);

    // Handshake: a write is taken on any cycle with cfg_valid && cfg_ready;
    // cfg_ready is low only while the single pending slot is occupied, and
    // the requester must hold cfg_ch/cfg_div stable while valid waits.

    logic                pend;
    logic [CH_IDX_W-1:0] pend_ch;
    logic [DIVW-1:0]     pend_div;
    logic                cfg_err_r;

    logic                accept;
    logic                ch_ok;
    logic                acc_ok;
    logic                pend_cond;
    logic                apply;
    logic [CH_IDX_W-1:0] apply_ch;
    logic [DIVW-1:0]     apply_div;
    logic [NCH-1:0]      ch_tick;
    logic [NCH-1:0]      ch_zero;

    assign cfg_ready = ~pend;
    assign cfg_err   = cfg_err_r;
    assign accept    = cfg_valid & cfg_ready;
    assign ch_ok     = (32'(cfg_ch) < 32'(NCH));
    assign acc_ok    = accept & ch_ok;
    assign tick      = ch_tick;

    always_comb begin
        pend_cond = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (pend_ch == CH_IDX_W'(k)) begin
                pend_cond = ch_tick[k] | ch_zero[k];
            end
        end
        pend_cond = pend_cond | ~en;
    end

    // A clear applies whatever is pending, or a write accepted alongside it.
    always_comb begin
        if (sync_clr) begin
            apply = pend | acc_ok;
        end else begin
            apply = pend & pend_cond;
        end
        apply_ch  = pend ? pend_ch  : cfg_ch;
        apply_div = pend ? pend_div : cfg_div;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_ch   <= '0;
            pend_div  <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= accept & ~ch_ok;
            if (apply) begin
                pend <= 1'b0;
            end else if (acc_ok && !sync_clr) begin
                pend     <= 1'b1;
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIVW    (DIVW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sync_clr (sync_clr),
            .load     (apply && (apply_ch == CH_IDX_W'(g))),
            .load_div (apply_div),
            .tick     (ch_tick[g]),
            .sq       (sq[g]),
            .div_zero (ch_zero[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-cycle scoreboard of all outputs
// against a behavioural model, plus directed scenario checks.
module tb_clk_div_bank;

    localparam int NCH     = 4;
    localparam int DIVW    = 25;
    localparam int DEF_DIV = 2;
    localparam int W       = 2 * NCH + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            sync_clr = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [3:0]      cfg_ch = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic            cfg_err;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  sq;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    int   m_cnt[NCH];
    int   m_div[NCH];
    logic m_sq[NCH];
    logic m_pend;
    int   m_pch;
    int   m_pdiv;
    logic m_err;

    logic [NCH-1:0] last_tick;
    logic [NCH-1:0] last_sq;
    logic           last_ready;
    logic           last_err;

    clk_div_bank #(
        .NCH     (NCH),
        .DIVW    (DIVW),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk = ~clk;

    function automatic logic mtick(input int k, input logic e, input logic s);
        return e && !s && (m_div[k] != 0) && (m_cnt[k] == m_div[k] - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k] = 0;
            m_div[k] = DEF_DIV;
            m_sq[k]  = 1'b0;
        end
        m_pend = 1'b0;
        m_pch  = 0;
        m_pdiv = 0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_advance(input logic e, input logic s, input logic v,
                                 input int c, input int d);
        logic tk[NCH];
        logic acc, ok, app;
        int   ach, adiv;
        for (int k = 0; k < NCH; k++) tk[k] = mtick(k, e, s);
        acc   = v && !m_pend;
        ok    = acc && (c < NCH);
        m_err = acc && !ok;
        app   = 1'b0;
        ach   = m_pch;
        adiv  = m_pdiv;
        if (s) begin
            if (m_pend) app = 1'b1;
            else if (ok) begin
                app  = 1'b1;
                ach  = c;
                adiv = d;
            end
        end else if (m_pend && (tk[m_pch] || m_div[m_pch] == 0 || !e)) begin
            app = 1'b1;
        end
        if (app) m_pend = 1'b0;
        else if (ok && !s) begin
            m_pend = 1'b1;
            m_pch  = c;
            m_pdiv = d;
        end
        for (int k = 0; k < NCH; k++) begin
            if (s) begin
                m_cnt[k] = 0;
                m_sq[k]  = 1'b0;
                if (app && ach == k) m_div[k] = adiv;
            end else if (app && ach == k) begin
                m_sq[k]  = (adiv == 0) ? 1'b0 : (tk[k] ? !m_sq[k] : m_sq[k]);
                m_cnt[k] = 0;
                m_div[k] = adiv;
            end else if (m_div[k] == 0) begin
                m_cnt[k] = 0;
                m_sq[k]  = 1'b0;
            end else if (e) begin
                if (tk[k]) m_sq[k] = !m_sq[k];
                m_cnt[k] = (m_cnt[k] == m_div[k] - 1) ? 0 : m_cnt[k] + 1;
            end
        end
    endtask

    // One clock cycle: drive, queue the model's prediction, compare, advance.
    task automatic step(input logic e, input logic s, input logic v,
                        input int c, input int d);
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        @(negedge clk);
        en        = e;
        sync_clr  = s;
        cfg_valid = v;
        cfg_ch    = 4'(c);
        cfg_div   = DIVW'(d);
        #1;
        for (int k = 0; k < NCH; k++) begin
            exp_v[NCH + 2 + k] = mtick(k, e, s);
            exp_v[2 + k]       = m_sq[k];
        end
        exp_v[1] = !m_pend;
        exp_v[0] = m_err;
        exp_q.push_back(exp_v);
        got   = {tick, sq, cfg_ready, cfg_err};
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs {tick,sq,ready,err}: got %b expected %b at %0t",
                     got, exp_v, $time);
        end
        last_tick  = tick;
        last_sq    = sq;
        last_ready = cfg_ready;
        last_err   = cfg_err;
        model_advance(e, s, v, c, d);
    endtask

    task automatic idle_inputs();
        en        = 1'b0;
        sync_clr  = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tick, sq, cfg_ready, cfg_err} !== {{NCH{1'b0}}, {NCH{1'b0}}, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", {tick, sq, cfg_ready, cfg_err},
                     {{NCH{1'b0}}, {NCH{1'b0}}, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_default_div();
        int nt[NCH];
        logic [7:0] sq_hist;
        for (int k = 0; k < NCH; k++) nt[k] = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0);
            sq_hist[i] = last_sq[0];
            for (int k = 0; k < NCH; k++) if (last_tick[k]) nt[k]++;
        end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (nt[k] !== 4) begin
                errors++;
                $display("FAIL default_tick_count ch%0d: got %0d expected 4", k, nt[k]);
            end
        end
        checks++;
        if (sq_hist !== 8'b1100_1100) begin
            errors++;
            $display("FAIL default_sq_pattern: got %b expected 11001100", sq_hist);
        end
    endtask

    task automatic test_write_defer();
        logic [12:0] th;
        logic [12:0] rh;
        step(0, 0, 1, 1, 3);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            if (i == 0) step(1, 0, 1, 1, 5);
            else step(1, 0, 0, 0, 0);
            th[i] = last_tick[1];
            rh[i] = last_ready;
        end
        checks++;
        if (th !== 13'b1_0000_1000_0100) begin
            errors++;
            $display("FAIL defer_tick1_positions: got %b expected 1000010000100", th);
        end
        checks++;
        if (rh !== 13'b1_1111_1111_1001) begin
            errors++;
            $display("FAIL defer_ready_window: got %b expected 1111111111001", rh);
        end
    endtask

    task automatic test_bad_channel();
        logic [4:0] eh;
        logic [4:0] rh;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1, 0, 1, 9, 4);
            else step(1, 0, 0, 0, 0);
            eh[i] = last_err;
            rh[i] = last_ready;
        end
        checks++;
        if (eh !== 5'b00010) begin
            errors++;
            $display("FAIL bad_ch_err_pulse: got %b expected 00010", eh);
        end
        checks++;
        if (rh !== 5'b11111) begin
            errors++;
            $display("FAIL bad_ch_ready: got %b expected 11111", rh);
        end
    endtask

    task automatic test_sync_clr();
        logic [7:0] t0;
        logic [7:0] t1;
        step(0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 7);
        step(0, 0, 0, 0, 0);
        repeat ($urandom_range(4, 15)) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0);
            t0[i] = last_tick[0];
            t1[i] = last_tick[1];
            if (i == 0) begin
                checks++;
                if (last_sq !== '0) begin
                    errors++;
                    $display("FAIL sync_sq_cleared: got %b expected 0", last_sq);
                end
            end
        end
        checks++;
        if (t0 !== 8'b0010_0100) begin
            errors++;
            $display("FAIL sync_tick0_positions: got %b expected 00100100", t0);
        end
        checks++;
        if (t1 !== 8'b0100_0000) begin
            errors++;
            $display("FAIL sync_tick1_positions: got %b expected 01000000", t1);
        end
    endtask

    task automatic test_div_one();
        int   chg;
        logic prev;
        logic applied;
        step(1, 0, 1, 0, 1);
        applied = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0);
            if (last_ready) begin
                applied = 1'b1;
                break;
            end
        end
        checks++;
        if (!applied) begin
            errors++;
            $display("FAIL div1_apply_timeout: ready got 0 expected 1 within 10 cycles");
        end
        chg  = 0;
        prev = last_sq[0];
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 0);
            checks++;
            if (last_tick[0] !== 1'b1) begin
                errors++;
                $display("FAIL div1_tick_high: got %b expected 1", last_tick[0]);
            end
            if (last_sq[0] !== prev) chg++;
            prev = last_sq[0];
        end
        checks++;
        if (chg !== 6) begin
            errors++;
            $display("FAIL div1_sq_toggles: got %0d expected 6", chg);
        end
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            checks++;
            if ({last_tick[0], last_sq[0]} !== 2'b00) begin
                errors++;
                $display("FAIL div0_forced_low: got tick=%b sq=%b expected 0 0",
                         last_tick[0], last_sq[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        int nt;
        step(0, 0, 1, 2, 20);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 2, 9);
        step(1, 0, 0, 0, 0);
        checks++;
        if (last_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_pending: ready got %b expected 0", last_ready);
        end
        @(negedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick, sq, cfg_ready, cfg_err} !== {{NCH{1'b0}}, {NCH{1'b0}}, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_values: got %b expected %b", {tick, sq, cfg_ready, cfg_err},
                     {{NCH{1'b0}}, {NCH{1'b0}}, 1'b1, 1'b0});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        nt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 0, 0, 0);
            if (last_tick[2]) nt++;
        end
        checks++;
        if (nt !== 15) begin
            errors++;
            $display("FAIL post_reset_ch2_ticks: got %0d expected 15", nt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 6));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_div();
        test_write_defer();
        test_bad_channel();
        test_sync_clr();
        test_div_one();
        test_async_reset();
        test_random();
        step(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
